lc3_ctrl_seq: RTL and testbench
===============================

// Module: lc3_ctrl_seq
// PURPOSE
// Microsequencer for the LC-3 datapath subset: fetch, decode, ADD/AND/NOT, BR, LD.
// Drives load enables, bus gates and mux selects for the MAR/MDR/IR/PC/REG/CC/BEN loads.
// Sequences the condition-code registers (LD_CC) and the branch comparator (LD_BEN).
// Handles memory through a ready handshake with a wait-timeout fault.
// PARAMETERS
// MEM_TIMEOUT  16  max consecutive wait cycles without MEM_R before FAULT (>=1)
// PORTS
// CLK        in   1  clock, rising edge
// RESET_N    in   1  synchronous active-low reset
// OPCODE     in   4  IR[15:12] of the currently loaded instruction
// BEN        in   1  registered branch-enable from the BR comparator
// MEM_R      in   1  memory ready; read data valid this cycle
// LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out 1 each  register loads
// GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers, at most one high
// PCMUX      out  2  00 PC+1, 01 BUS, 10 address adder
// ADDR1MUX   out  1  0 PC, 1 SR1
// ADDR2MUX   out  2  00 zero, 01 off6, 10 off9, 11 off11
// MARMUX     out  1  0 zext(IR[7:0]), 1 address adder
// ALUK       out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
// DRMUX, SR1MUX  out 1 each  0 IR[11:9], 1 IR[8:6] (SR1MUX) / R7 (DRMUX)
// MIO_EN, R_W  out 1 each  memory enable, 0 = read
// ILLEGAL    out  1  one-cycle pulse when DECODE sees an unsupported opcode
// FAULT      out  1  sticky memory timeout flag
// STATE      out  6  current state number (LC-3 numbering), debug
// BEHAVIOUR
// - Moore outputs decoded from registered state. Exception: LD_MDR = MEM_R in the wait states.
// - While RESET_N=0, every output is 0. At the first CLK edge with RESET_N=0: state<=FETCH1, wait counter<=0, FAULT<=0.
// - FETCH1(18): GatePC, LD_MAR, LD_PC, PCMUX=00 -> FETCH2.
// - FETCH2(33): MIO_EN, R_W=0, LD_MDR=MEM_R.
//   - MEM_R=1 -> FETCH3; otherwise stay.
// - FETCH3(35): GateMDR, LD_IR -> DECODE.
// - DECODE(32): LD_BEN. Next state by OPCODE:
//   - 0000 BR, 0001 ADD, 0101 AND, 1001 NOT, 0010 LD.
//   - Any other opcode: ILLEGAL=1 for this cycle only, next state FETCH1 (NOP).
// - ADD(1)/AND(5)/NOT(9): GateALU, LD_REG, LD_CC, DRMUX=0, SR1MUX=1; ALUK=00/01/10 -> FETCH1.
// - BR(0): no outputs. BEN=1 -> BR_TAKEN, else FETCH1. BEN is sampled here, one cycle after LD_BEN.
// - BR_TAKEN(22): LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10 -> FETCH1.
// - LD(2): GateMARMUX, LD_MAR, MARMUX=1, ADDR1MUX=0, ADDR2MUX=10 -> LD_MEM.
// - LD_MEM(25): same handshake as FETCH2. MEM_R=1 -> LD_WB.
// - LD_WB(27): GateMDR, LD_REG, LD_CC, DRMUX=0 -> FETCH1.
// - Wait counter: increments each wait-state cycle with MEM_R=0; clears on leaving the wait state.
//   - MEM_R=1 on the same cycle the count reaches MEM_TIMEOUT-1: the ready wins; normal advance.
//   - MEM_TIMEOUT cycles with MEM_R=0: next state FAULT(63), FAULT<=1.
// - FAULT state: all controls 0, STATE=63. Only reset exits it.
// - Cycle counts with zero-wait memory (MEM_R=1 in the first wait cycle):
//   - ALU op 5 cycles; BR not-taken 5, taken 6; LD 7.
// - Each extra wait cycle adds exactly 1 cycle.
// - Reset mid-instruction: abandons it; no partial LD_REG/LD_CC after reset.
// TESTING
// 1 Hold RESET_N=0 two cycles, release -> all outputs 0 while low; first cycle after release STATE=18 with GatePC=LD_MAR=LD_PC=1.
// 2 OPCODE=0001, MEM_R low 3 cycles then high -> FETCH2 held 4 cycles, LD_MDR high only on the ready cycle; ADD cycle shows LD_REG=LD_CC=1, ALUK=00.
// 3 OPCODE=0000, BEN=1 -> 18,33,35,32,0,22 with LD_PC=1, PCMUX=10 in 22; repeat with BEN=0 -> 0 then 18.
// 4 OPCODE=0010, MEM_R=1 -> 18,33,35,32,2,25,27,18; LD_CC=1 only in 27.
// 5 MEM_TIMEOUT=8, MEM_R=0 forever -> 8 cycles in 33 then STATE=63, FAULT=1 persists until RESET_N=0.
// 6 OPCODE=1101 -> ILLEGAL=1 for exactly the DECODE cycle, then STATE=18; no LD_REG/LD_CC pulses.

Source files
------------

// File: rtl/lc3_ctrl_seq_if.sv
// Control bundle between the LC-3 microsequencer and the datapath/memory it steers.
// The master side is the sequencer; the slave side is the datapath.
interface lc3_ctrl_seq_if;
   logic [3:0] opcode;
   logic       ben;
   logic       mem_r;
   logic       ld_mar;
   logic       ld_mdr;
   logic       ld_ir;
   logic       ld_ben;
   logic       ld_reg;
   logic       ld_cc;
   logic       ld_pc;
   logic       gate_pc;
   logic       gate_mdr;
   logic       gate_alu;
   logic       gate_marmux;
   logic [1:0] pcmux;
   logic       addr1mux;
   logic [1:0] addr2mux;
   logic       marmux;
   logic [1:0] aluk;
   logic       drmux;
   logic       sr1mux;
   logic       mio_en;
   logic       r_w;
   logic       illegal;
   logic       fault;
   logic [5:0] state;

   modport master (
      input  opcode, ben, mem_r,
      output ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
      output gate_pc, gate_mdr, gate_alu, gate_marmux,
      output pcmux, addr1mux, addr2mux, marmux, aluk, drmux, sr1mux,
      output mio_en, r_w, illegal, fault, state
   );

   modport slave (
      output opcode, ben, mem_r,
      input  ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
      input  gate_pc, gate_mdr, gate_alu, gate_marmux,
      input  pcmux, addr1mux, addr2mux, marmux, aluk, drmux, sr1mux,
      input  mio_en, r_w, illegal, fault, state
   );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// LC-3 microsequencer (fetch, decode, ADD/AND/NOT, BR, LD) with a memory-ready
// wait counter that traps into a sticky FAULT state on timeout.
module lc3_ctrl_seq #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   lc3_ctrl_seq_if.master      bus
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [5:0] {
      S_BR       = 6'd0,
      S_ADD      = 6'd1,
      S_LD       = 6'd2,
      S_AND      = 6'd5,
      S_NOT      = 6'd9,
      S_FETCH1   = 6'd18,
      S_BR_TAKEN = 6'd22,
      S_LD_MEM   = 6'd25,
      S_LD_WB    = 6'd27,
      S_DECODE   = 6'd32,
      S_FETCH2   = 6'd33,
      S_FETCH3   = 6'd35,
      S_FAULT    = 6'd63
   } state_e;

   state_e        state_q;
   logic [CW-1:0] wait_q;
   logic          fault_q;

   // State register, memory wait counter and sticky fault flag.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= S_FETCH1;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH1: state_q <= S_FETCH2;
            S_FETCH2, S_LD_MEM: begin
               // A ready arriving on the last allowed wait cycle still wins.
               if (bus.mem_r) begin
                  wait_q  <= '0;
                  state_q <= (state_q == S_FETCH2) ? S_FETCH3 : S_LD_WB;
               end else if (wait_q == CNT_LAST) begin
                  wait_q  <= '0;
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_FETCH3: state_q <= S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  4'b0000: state_q <= S_BR;
                  4'b0001: state_q <= S_ADD;
                  4'b0101: state_q <= S_AND;
                  4'b1001: state_q <= S_NOT;
                  4'b0010: state_q <= S_LD;
                  default: state_q <= S_FETCH1;
               endcase
            end
            S_ADD, S_AND, S_NOT: state_q <= S_FETCH1;
            S_BR:       state_q <= bus.ben ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: state_q <= S_FETCH1;
            S_LD:       state_q <= S_LD_MEM;
            S_LD_WB:    state_q <= S_FETCH1;
            S_FAULT:    state_q <= S_FAULT;
            default:    state_q <= S_FETCH1;
         endcase
      end
   end

   // Moore control decode; everything is forced low while reset is asserted.
   always_comb begin
      bus.ld_mar      = 1'b0;
      bus.ld_mdr      = 1'b0;
      bus.ld_ir       = 1'b0;
      bus.ld_ben      = 1'b0;
      bus.ld_reg      = 1'b0;
      bus.ld_cc       = 1'b0;
      bus.ld_pc       = 1'b0;
      bus.gate_pc     = 1'b0;
      bus.gate_mdr    = 1'b0;
      bus.gate_alu    = 1'b0;
      bus.gate_marmux = 1'b0;
      bus.pcmux       = 2'b00;
      bus.addr1mux    = 1'b0;
      bus.addr2mux    = 2'b00;
      bus.marmux      = 1'b0;
      bus.aluk        = 2'b00;
      bus.drmux       = 1'b0;
      bus.sr1mux      = 1'b0;
      bus.mio_en      = 1'b0;
      bus.r_w         = 1'b0;
      bus.illegal     = 1'b0;
      bus.fault       = 1'b0;
      bus.state       = 6'd0;
      if (reset_n_i) begin
         bus.state = state_q;
         bus.fault = fault_q;
         case (state_q)
            S_FETCH1: begin
               bus.gate_pc = 1'b1;
               bus.ld_mar  = 1'b1;
               bus.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LD_MEM: begin
               bus.mio_en = 1'b1;
               bus.ld_mdr = bus.mem_r;
            end
            S_FETCH3: begin
               bus.gate_mdr = 1'b1;
               bus.ld_ir    = 1'b1;
            end
            S_DECODE: begin
               bus.ld_ben = 1'b1;
               case (bus.opcode)
                  4'b0000, 4'b0001, 4'b0101, 4'b1001, 4'b0010: bus.illegal = 1'b0;
                  default: bus.illegal = 1'b1;
               endcase
            end
            S_ADD, S_AND, S_NOT: begin
               bus.gate_alu = 1'b1;
               bus.ld_reg   = 1'b1;
               bus.ld_cc    = 1'b1;
               bus.sr1mux   = 1'b1;
               bus.aluk     = (state_q == S_ADD) ? 2'b00 :
                              (state_q == S_AND) ? 2'b01 : 2'b10;
            end
            S_BR_TAKEN: begin
               bus.ld_pc    = 1'b1;
               bus.pcmux    = 2'b10;
               bus.addr2mux = 2'b10;
            end
            S_LD: begin
               bus.gate_marmux = 1'b1;
               bus.ld_mar      = 1'b1;
               bus.marmux      = 1'b1;
               bus.addr2mux    = 2'b10;
            end
            S_LD_WB: begin
               bus.gate_mdr = 1'b1;
               bus.ld_reg   = 1'b1;
               bus.ld_cc    = 1'b1;
            end
            default: bus.ld_mar = 1'b0;
         endcase
      end else begin
         bus.state = 6'd0;
      end
   end
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Scoreboard bench for lc3_ctrl_seq: each driven cycle pushes the expected control
// vector, and a negedge monitor pops and compares it with the DUT outputs.
module tb_lc3_ctrl_seq;
   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_pass;
   int   cyc_n;

   typedef struct {
      string       tag;
      logic [31:0] vec;
   } sb_t;
   sb_t sb_q[$];

   lc3_ctrl_seq_if bus_if ();

   lc3_ctrl_seq #(.MEM_TIMEOUT(8)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] obs_vec();
      return {1'b0, bus_if.state, bus_if.fault, bus_if.illegal,
              bus_if.ld_mar, bus_if.ld_mdr, bus_if.ld_ir, bus_if.ld_ben,
              bus_if.ld_reg, bus_if.ld_cc, bus_if.ld_pc,
              bus_if.gate_pc, bus_if.gate_mdr, bus_if.gate_alu, bus_if.gate_marmux,
              bus_if.pcmux, bus_if.addr1mux, bus_if.addr2mux, bus_if.marmux,
              bus_if.aluk, bus_if.drmux, bus_if.sr1mux, bus_if.mio_en, bus_if.r_w};
   endfunction

   // Expected controls from the state table, independent of the DUT.
   function automatic logic [31:0] exp_vec(input logic rn, input logic [5:0] st,
                                           input logic [3:0] op, input logic mr);
      logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
      logic g_pc, g_mdr, g_alu, g_mm, a1, mm, dr, sr1, mio, ill, flt;
      logic [1:0] pcm, a2, alu;
      {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc} = 7'd0;
      {g_pc, g_mdr, g_alu, g_mm, a1, mm, dr, sr1, mio, ill, flt} = 11'd0;
      pcm = 2'b00; a2 = 2'b00; alu = 2'b00;
      if (!rn) return 32'd0;
      case (st)
         6'd18: begin g_pc = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1; end
         6'd33, 6'd25: begin mio = 1'b1; ld_mdr = mr; end
         6'd35: begin g_mdr = 1'b1; ld_ir = 1'b1; end
         6'd32: begin
            ld_ben = 1'b1;
            ill = !(op == 4'd0 || op == 4'd1 || op == 4'd5 || op == 4'd9 || op == 4'd2);
         end
         6'd1, 6'd5, 6'd9: begin
            g_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; sr1 = 1'b1;
            alu = (st == 6'd1) ? 2'b00 : (st == 6'd5) ? 2'b01 : 2'b10;
         end
         6'd22: begin ld_pc = 1'b1; pcm = 2'b10; a2 = 2'b10; end
         6'd2:  begin g_mm = 1'b1; ld_mar = 1'b1; mm = 1'b1; a2 = 2'b10; end
         6'd27: begin g_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; end
         6'd63: flt = 1'b1;
         default: flt = 1'b0;
      endcase
      return {1'b0, st, flt, ill, ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
              g_pc, g_mdr, g_alu, g_mm, pcm, a1, a2, mm, alu, dr, sr1, mio, 1'b0};
   endfunction

   // Drive one cycle just after the edge and queue what the DUT should show.
   task automatic drive(input string tag, input logic rn, input logic [3:0] op,
                        input logic b, input logic mr, input logic [5:0] es);
      sb_t e;
      @(posedge clk);
      #1;
      reset_n       = rn;
      bus_if.opcode = op;
      bus_if.ben    = b;
      bus_if.mem_r  = mr;
      cyc_n         = cyc_n + 1;
      e.tag = $sformatf("%s@%0d", tag, cyc_n);
      e.vec = exp_vec(rn, es, op, mr);
      sb_q.push_back(e);
   endtask

   // Monitor: pop the expectation for this cycle and compare at the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check_eq(e.tag, obs_vec(), e.vec);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_pass = 0; cyc_n = 0;
      reset_n = 1'b0;
      bus_if.opcode = 4'd0; bus_if.ben = 1'b0; bus_if.mem_r = 1'b0;
      // reset held two cycles, outputs all zero
      drive("rst", 1'b0, 4'd1, 1'b0, 1'b0, 6'd0);
      drive("rst", 1'b0, 4'd1, 1'b0, 1'b1, 6'd0);
      // ADD with three wait cycles
      drive("add", 1'b1, 4'd1, 1'b0, 1'b0, 6'd18);
      for (int i = 0; i < 3; i++) drive("add_wait", 1'b1, 4'd1, 1'b0, 1'b0, 6'd33);
      drive("add_rdy", 1'b1, 4'd1, 1'b0, 1'b1, 6'd33);
      drive("add", 1'b1, 4'd1, 1'b0, 1'b0, 6'd35);
      drive("add", 1'b1, 4'd1, 1'b0, 1'b0, 6'd32);
      drive("add_ex", 1'b1, 4'd1, 1'b0, 1'b0, 6'd1);
      // AND and NOT, zero-wait
      drive("and", 1'b1, 4'd5, 1'b0, 1'b1, 6'd18);
      drive("and", 1'b1, 4'd5, 1'b0, 1'b1, 6'd33);
      drive("and", 1'b1, 4'd5, 1'b0, 1'b1, 6'd35);
      drive("and", 1'b1, 4'd5, 1'b0, 1'b1, 6'd32);
      drive("and_ex", 1'b1, 4'd5, 1'b0, 1'b1, 6'd5);
      drive("not", 1'b1, 4'd9, 1'b0, 1'b1, 6'd18);
      drive("not", 1'b1, 4'd9, 1'b0, 1'b1, 6'd33);
      drive("not", 1'b1, 4'd9, 1'b0, 1'b1, 6'd35);
      drive("not", 1'b1, 4'd9, 1'b0, 1'b1, 6'd32);
      drive("not_ex", 1'b1, 4'd9, 1'b0, 1'b1, 6'd9);
      // BR taken then not taken
      drive("brt", 1'b1, 4'd0, 1'b1, 1'b1, 6'd18);
      drive("brt", 1'b1, 4'd0, 1'b1, 1'b1, 6'd33);
      drive("brt", 1'b1, 4'd0, 1'b1, 1'b1, 6'd35);
      drive("brt", 1'b1, 4'd0, 1'b1, 1'b1, 6'd32);
      drive("brt", 1'b1, 4'd0, 1'b1, 1'b1, 6'd0);
      drive("brt_tk", 1'b1, 4'd0, 1'b1, 1'b1, 6'd22);
      drive("brn", 1'b1, 4'd0, 1'b0, 1'b1, 6'd18);
      drive("brn", 1'b1, 4'd0, 1'b0, 1'b1, 6'd33);
      drive("brn", 1'b1, 4'd0, 1'b0, 1'b1, 6'd35);
      drive("brn", 1'b1, 4'd0, 1'b0, 1'b1, 6'd32);
      drive("brn", 1'b1, 4'd0, 1'b0, 1'b1, 6'd0);
      // LD zero-wait
      drive("ld", 1'b1, 4'd2, 1'b0, 1'b1, 6'd18);
      drive("ld", 1'b1, 4'd2, 1'b0, 1'b1, 6'd33);
      drive("ld", 1'b1, 4'd2, 1'b0, 1'b1, 6'd35);
      drive("ld", 1'b1, 4'd2, 1'b0, 1'b1, 6'd32);
      drive("ld", 1'b1, 4'd2, 1'b0, 1'b1, 6'd2);
      drive("ld_mem", 1'b1, 4'd2, 1'b0, 1'b1, 6'd25);
      drive("ld_wb", 1'b1, 4'd2, 1'b0, 1'b1, 6'd27);
      // LD with ready on the last permitted wait cycle
      drive("ldw", 1'b1, 4'd2, 1'b0, 1'b1, 6'd18);
      drive("ldw", 1'b1, 4'd2, 1'b0, 1'b1, 6'd33);
      drive("ldw", 1'b1, 4'd2, 1'b0, 1'b1, 6'd35);
      drive("ldw", 1'b1, 4'd2, 1'b0, 1'b1, 6'd32);
      drive("ldw", 1'b1, 4'd2, 1'b0, 1'b0, 6'd2);
      for (int i = 0; i < 7; i++) drive("ldw_wait", 1'b1, 4'd2, 1'b0, 1'b0, 6'd25);
      drive("ldw_rdy", 1'b1, 4'd2, 1'b0, 1'b1, 6'd25);
      drive("ldw_wb", 1'b1, 4'd2, 1'b0, 1'b1, 6'd27);
      // illegal opcode
      drive("ill", 1'b1, 4'd13, 1'b0, 1'b1, 6'd18);
      drive("ill", 1'b1, 4'd13, 1'b0, 1'b1, 6'd33);
      drive("ill", 1'b1, 4'd13, 1'b0, 1'b1, 6'd35);
      drive("ill_dec", 1'b1, 4'd13, 1'b0, 1'b1, 6'd32);
      drive("ill_nop", 1'b1, 4'd13, 1'b0, 1'b1, 6'd18);
      // reset mid-instruction abandons the ADD
      drive("mid", 1'b1, 4'd1, 1'b0, 1'b1, 6'd33);
      drive("mid", 1'b1, 4'd1, 1'b0, 1'b1, 6'd35);
      drive("mid", 1'b1, 4'd1, 1'b0, 1'b1, 6'd32);
      drive("mid_rst", 1'b0, 4'd1, 1'b0, 1'b1, 6'd0);
      drive("mid_rel", 1'b1, 4'd1, 1'b0, 1'b1, 6'd18);
      // memory timeout into sticky fault
      for (int i = 0; i < 8; i++) drive("to_wait", 1'b1, 4'd1, 1'b0, 1'b0, 6'd33);
      drive("fault", 1'b1, 4'd1, 1'b0, 1'b0, 6'd63);
      for (int i = 0; i < 3; i++) drive("fault_hold", 1'b1, 4'd1, 1'b1, 1'b1, 6'd63);
      drive("fault_rst", 1'b0, 4'd1, 1'b0, 1'b0, 6'd0);
      drive("fault_rel", 1'b1, 4'd1, 1'b0, 1'b0, 6'd18);
      drive("fault_rel", 1'b1, 4'd1, 1'b0, 1'b1, 6'd33);
      @(posedge clk);
      @(posedge clk);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
